// File: rtl/oled_responder_if.sv
// Pad-side signals of the 8-bit parallel RS / R-!W / E character-OLED bus.
// The host end uses the master view and the display end uses the slave view.
interface oled_responder_if;
    logic       rs_pin;
    logic       read_pin;
    logic       enable_pin;
    logic [7:0] db_in;
    logic [7:0] db_out;
    logic       db_oe;

    modport master (
        output rs_pin, read_pin, enable_pin, db_in,
        input  db_out, db_oe
    );

    modport slave (
        input  rs_pin, read_pin, enable_pin, db_in,
        output db_out, db_oe
    );
endinterface

// File: rtl/oled_responder.sv
// Display end of the character-OLED parallel bus. It decodes host write strobes into
// {rs,data} words, tracks the address counter and busy time, and answers status/data reads.
module oled_responder #(
    parameter int unsigned POR_CYCLES   = 1000,
    parameter int unsigned CMD_CYCLES   = 40,
    parameter int unsigned CLEAR_CYCLES = 2000,
    parameter int unsigned DATA_CYCLES  = 40
) (
    input  logic            clk,
    input  logic            reset_n,
    oled_responder_if.slave bus,
    output logic            cmd_valid,
    output logic [8:0]      cmd_data,
    output logic [6:0]      ac,
    input  logic [7:0]      rd_data,
    output logic            busy,
    output logic            overrun
);

    localparam int unsigned MAX_AB     = (POR_CYCLES > CMD_CYCLES) ? POR_CYCLES : CMD_CYCLES;
    localparam int unsigned MAX_CD     = (CLEAR_CYCLES > DATA_CYCLES) ? CLEAR_CYCLES : DATA_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] POR_LOAD   = CNT_W'(POR_CYCLES);
    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_CYCLES);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);
    localparam logic [CNT_W-1:0] DATA_LOAD  = CNT_W'(DATA_CYCLES);

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic       e;
        logic [7:0] db;
    } pins_t;

    pins_t            pins_in;
    pins_t            sync1_q, sync1_d;
    pins_t            sync2_q, sync2_d;
    logic             e_q, e_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [6:0]       ac_q, ac_d;
    logic             inc_q, inc_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [8:0]       cmd_data_q, cmd_data_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       db_out_q, db_out_d;
    logic             db_oe_q, db_oe_d;

    logic       rs_s, rw_s, e_s;
    logic [7:0] db_s;
    logic       e_rise, e_fall;
    logic       busy_w, write_blocked;
    logic [6:0] ac_step;

    // All four bus inputs share one chain so strobe, direction and data stay cycle-aligned.
    assign pins_in = '{rs: bus.rs_pin, rw: bus.read_pin, e: bus.enable_pin, db: bus.db_in};

    assign rs_s = sync2_q.rs;
    assign rw_s = sync2_q.rw;
    assign e_s  = sync2_q.e;
    assign db_s = sync2_q.db;

    assign e_rise = e_s & ~e_q;
    assign e_fall = ~e_s & e_q;

    assign busy_w = (busy_cnt_q != '0);
    // A counter in its final busy cycle lets a coincident write through rather than dropping it.
    assign write_blocked = (busy_cnt_q > CNT_W'(1));
    assign ac_step       = inc_q ? (ac_q + 7'd1) : (ac_q - 7'd1);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        sync1_d     = pins_in;
        sync2_d     = sync1_q;
        e_d         = e_s;
        ac_d        = ac_q;
        inc_d       = inc_q;
        cmd_valid_d = 1'b0;
        cmd_data_d  = cmd_data_q;
        overrun_d   = 1'b0;
        db_oe_d     = rw_s;
        db_out_d    = db_out_q;
        busy_cnt_d  = busy_w ? (busy_cnt_q - CNT_W'(1)) : '0;

        if (e_rise && rw_s) begin
            db_out_d = rs_s ? rd_data : {busy_w, ac_q};
        end

        if (e_fall && rw_s && rs_s) begin
            ac_d = ac_step;
        end

        if (e_fall && !rw_s) begin
            if (write_blocked) begin
                overrun_d = 1'b1;
            end else begin
                cmd_valid_d = 1'b1;
                cmd_data_d  = {rs_s, db_s};
                if (rs_s) begin
                    ac_d       = ac_step;
                    busy_cnt_d = DATA_LOAD;
                end else if (db_s == 8'h01) begin
                    ac_d       = 7'd0;
                    inc_d      = 1'b1;
                    busy_cnt_d = CLEAR_LOAD;
                end else if (db_s[7:1] == 7'b000_0001) begin
                    ac_d       = 7'd0;
                    busy_cnt_d = CLEAR_LOAD;
                end else if (db_s[7:2] == 6'b00_0001) begin
                    inc_d      = db_s[1];
                    busy_cnt_d = CMD_LOAD;
                end else if (db_s[7]) begin
                    ac_d       = db_s[6:0];
                    busy_cnt_d = CMD_LOAD;
                end else begin
                    busy_cnt_d = CMD_LOAD;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            e_q         <= 1'b0;
            busy_cnt_q  <= POR_LOAD;
            ac_q        <= 7'd0;
            inc_q       <= 1'b1;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= 9'd0;
            overrun_q   <= 1'b0;
            db_out_q    <= 8'd0;
            db_oe_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            e_q         <= e_d;
            busy_cnt_q  <= busy_cnt_d;
            ac_q        <= ac_d;
            inc_q       <= inc_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            overrun_q   <= overrun_d;
            db_out_q    <= db_out_d;
            db_oe_q     <= db_oe_d;
        end
    end

    assign bus.db_out = db_out_q;
    assign bus.db_oe  = db_oe_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_data   = cmd_data_q;
    assign ac         = ac_q;
    assign busy       = busy_w;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_oled_responder.sv
// Bench for oled_responder: directed bus scenarios plus random traffic, all compared each
// cycle against a transaction-level display model driven from the same pin activity.
module tb_oled_responder;

    localparam int POR   = 50;
    localparam int CMD   = 16;
    localparam int CLEAR = 40;
    localparam int DATA  = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid;
    logic [8:0] cmd_data;
    logic [6:0] ac;
    logic [7:0] rd_data;
    logic       busy;
    logic       overrun;
    logic [7:0] mem [128];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_valid = 0;
    int n_ov    = 0;
    int valid_cyc = 0;

    oled_responder_if bus_if ();

    oled_responder #(
        .POR_CYCLES  (POR),
        .CMD_CYCLES  (CMD),
        .CLEAR_CYCLES(CLEAR),
        .DATA_CYCLES (DATA)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if.slave),
        .cmd_valid(cmd_valid),
        .cmd_data (cmd_data),
        .ac       (ac),
        .rd_data  (rd_data),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    assign rd_data = mem[ac];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       rs;
        logic       rw;
        logic       e;
        logic [7:0] db;
    } pin_t;

    typedef struct {
        int busy_left;
        int addr;
        bit incr;
        bit cv;
        int cd;
        bit ov;
        int dout;
        bit oe;
    } model_t;

    model_t m;
    pin_t   hist [3];

    function automatic model_t model_reset();
        model_t r;
        r.busy_left = POR;
        r.addr = 0;
        r.incr = 1'b1;
        r.cv = 1'b0;
        r.cd = 0;
        r.ov = 1'b0;
        r.dout = 0;
        r.oe = 1'b0;
        return r;
    endfunction

    function automatic int next_addr(int a, bit incr);
        return incr ? (a + 1) % 128 : (a + 127) % 128;
    endfunction

    // One clock of the display as seen through the 2-cycle input latency: 'seen' is the
    // pin state the display currently observes, 'prev' the one before it.
    function automatic model_t model_step(model_t s, pin_t seen, pin_t prev, logic [7:0] rdd);
        model_t n;
        bit rise;
        bit fall;
        int b;
        n = s;
        rise = seen.e && !prev.e;
        fall = !seen.e && prev.e;
        b = int'(seen.db);
        n.cv = 1'b0;
        n.ov = 1'b0;
        n.oe = seen.rw;
        n.busy_left = (s.busy_left > 0) ? s.busy_left - 1 : 0;
        if (rise && seen.rw)
            n.dout = seen.rs ? int'(rdd) : ((s.busy_left > 0) ? 128 : 0) + s.addr;
        if (fall && seen.rw && seen.rs)
            n.addr = next_addr(s.addr, s.incr);
        if (fall && !seen.rw) begin
            if (s.busy_left > 1) begin
                n.ov = 1'b1;
            end else begin
                n.cv = 1'b1;
                n.cd = (seen.rs ? 256 : 0) + b;
                if (seen.rs) begin
                    n.addr = next_addr(s.addr, s.incr);
                    n.busy_left = DATA;
                end else if (b == 1) begin
                    n.addr = 0;
                    n.incr = 1'b1;
                    n.busy_left = CLEAR;
                end else if (b == 2 || b == 3) begin
                    n.addr = 0;
                    n.busy_left = CLEAR;
                end else if (b >= 4 && b <= 7) begin
                    n.incr = seen.db[1];
                    n.busy_left = CMD;
                end else if (b >= 128) begin
                    n.addr = b - 128;
                    n.busy_left = CMD;
                end else begin
                    n.busy_left = CMD;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m <= model_reset();
            hist[0] <= '0;
            hist[1] <= '0;
            hist[2] <= '0;
        end else begin
            m <= model_step(m, hist[1], hist[2], mem[m.addr]);
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            hist[0] <= '{rs: bus_if.rs_pin, rw: bus_if.read_pin, e: bus_if.enable_pin, db: bus_if.db_in};
        end
    end

    always @(negedge clk) begin
        check("cycle{dbo,oe,cv,cd,ac,busy,ov}",
              {bus_if.db_out, bus_if.db_oe, cmd_valid, cmd_data, ac, busy, overrun},
              {8'(m.dout), m.oe, m.cv, 9'(m.cd), 7'(m.addr), m.busy_left != 0, m.ov});
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_valid) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
        end
        if (overrun) n_ov <= n_ov + 1;
    end

    // ---------------- host bus tasks ----------------
    task automatic bus_write(input logic rs, input logic [7:0] d);
        bus_if.rs_pin   = rs;
        bus_if.read_pin = 1'b0;
        bus_if.db_in    = d;
        repeat (2) @(negedge clk);
        bus_if.enable_pin = 1'b1;
        repeat (4) @(negedge clk);
        bus_if.enable_pin = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] d, output logic oe);
        bus_if.rs_pin   = rs;
        bus_if.read_pin = 1'b1;
        repeat (2) @(negedge clk);
        bus_if.enable_pin = 1'b1;
        repeat (4) @(negedge clk);
        d  = bus_if.db_out;
        oe = bus_if.db_oe;
        bus_if.enable_pin = 1'b0;
        repeat (4) @(negedge clk);
        bus_if.read_pin = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag, output logic [7:0] status);
        logic [7:0] d;
        logic       oe;
        bit         ok;
        ok = 1'b0;
        d  = 8'hFF;
        for (int i = 0; i < 200 && !ok; i++) begin
            bus_read(1'b0, d, oe);
            if (!d[7]) ok = 1'b1;
        end
        status = d;
        check({tag, "_poll_ready"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_busy_low(input string tag, output int at);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_bounded"}, 32'(busy), 32'd0);
        at = cyc;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] st;
        logic [7:0] d;
        logic       oe;
        int         c0;
        int         at;
        int         v0;
        int         o0;
        int         op;

        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        bus_if.rs_pin     = 1'b0;
        bus_if.read_pin   = 1'b0;
        bus_if.enable_pin = 1'b0;
        bus_if.db_in      = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_ac", 32'(ac), 32'h0);
        check("reset_busy", 32'(busy), 32'h1);
        check("reset_oe", 32'(bus_if.db_oe), 32'h0);

        // Power-on busy, observed through status reads and cycle count.
        reset_n = 1'b1;
        c0 = cyc;
        bus_read(1'b0, st, oe);
        check("t1_status_busy", 32'(st), 32'h80);
        check("t1_read_oe", 32'(oe), 32'h1);
        wait_busy_low("t1", at);
        check("t1_por_len", 32'(at - c0), 32'(POR));
        wait_ready("t1", st);
        check("t1_status_idle", 32'(st), 32'h00);

        // Function set 0x38.
        v0 = n_valid;
        bus_write(1'b0, 8'h38);
        check("t2_cmd_data", 32'(cmd_data), 32'h038);
        check("t2_one_valid", 32'(n_valid - v0), 32'd1);
        wait_busy_low("t2", at);
        check("t2_cmd_len", 32'(at - valid_cyc), 32'(CMD));

        // Address 0x7E then three data writes across the wrap.
        wait_ready("t3", st);
        bus_write(1'b0, 8'hFE);
        check("t3_set_addr", 32'(ac), 32'h7E);
        wait_ready("t3", st);
        bus_write(1'b1, 8'h41);
        check("t3_cd_A", 32'(cmd_data), 32'h141);
        check("t3_ac_A", 32'(ac), 32'h7F);
        wait_busy_low("t3", at);
        check("t3_data_len", 32'(at - valid_cyc), 32'(DATA));
        wait_ready("t3", st);
        bus_write(1'b1, 8'h42);
        check("t3_cd_B", 32'(cmd_data), 32'h142);
        check("t3_ac_B", 32'(ac), 32'h00);
        wait_ready("t3", st);
        bus_write(1'b1, 8'h43);
        check("t3_cd_C", 32'(cmd_data), 32'h143);
        check("t3_ac_C", 32'(ac), 32'h01);

        // Decrement mode, wrap below zero, then clear.
        wait_ready("t4", st);
        bus_write(1'b0, 8'h04);
        wait_ready("t4", st);
        bus_write(1'b0, 8'h80);
        wait_ready("t4", st);
        bus_write(1'b1, 8'h55);
        check("t4_ac_dec_wrap", 32'(ac), 32'h7F);
        wait_ready("t4", st);
        bus_write(1'b0, 8'h01);
        check("t4_clear_ac", 32'(ac), 32'h00);
        wait_busy_low("t4", at);
        check("t4_clear_len", 32'(at - valid_cyc), 32'(CLEAR));

        // Data write followed by another without polling: the second is dropped.
        wait_ready("t5", st);
        bus_write(1'b1, 8'h58);
        check("t5_ac_first", 32'(ac), 32'h01);
        v0 = n_valid;
        o0 = n_ov;
        bus_write(1'b1, 8'h59);
        check("t5_overrun_count", 32'(n_ov - o0), 32'd1);
        check("t5_no_valid", 32'(n_valid - v0), 32'd0);
        check("t5_ac_kept", 32'(ac), 32'h01);
        check("t5_cd_kept", 32'(cmd_data), 32'h158);

        // Random traffic, sometimes without polling.
        for (int i = 0; i < 120; i++) begin
            op = int'($urandom_range(0, 9));
            if ($urandom_range(0, 2) != 0) wait_ready("rnd", st);
            case (op)
                0, 1, 2, 3: bus_write(1'b1, 8'($urandom));
                4, 5:       bus_write(1'b0, 8'($urandom));
                6, 7:       bus_read(1'b0, d, oe);
                8:          bus_read(1'b1, d, oe);
                default:    repeat ($urandom_range(1, 25)) @(negedge clk);
            endcase
        end

        // Data read at ac=0x10, then reset in the middle of a read.
        wait_ready("t6", st);
        bus_write(1'b0, 8'h84);
        wait_ready("t6", st);
        bus_write(1'b0, 8'h06);
        wait_ready("t6", st);
        bus_write(1'b0, 8'h90);
        wait_ready("t6", st);
        mem[16] = 8'h5A;
        bus_read(1'b1, d, oe);
        check("t6_read_data", 32'(d), 32'h5A);
        check("t6_read_oe", 32'(oe), 32'h1);
        check("t6_ac_step", 32'(ac), 32'h11);

        bus_if.rs_pin   = 1'b1;
        bus_if.read_pin = 1'b1;
        repeat (2) @(negedge clk);
        bus_if.enable_pin = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_oe_before_reset", 32'(bus_if.db_oe), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_oe_reset", 32'(bus_if.db_oe), 32'h0);
        check("t6_ac_reset", 32'(ac), 32'h0);
        @(negedge clk);
        bus_if.enable_pin = 1'b0;
        bus_if.read_pin   = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_busy_after_reset", 32'(busy), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
